alu_iter: RTL and testbench

//  N-bit sequential ALU for the multi-cycle RISC-V datapath: RV32I ALU ops plus iterative MUL/DIVU/REMU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter_if.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 69 ++++++
 rtl/alu_iter.sv | 117 +++++++++++
 tb/tb_alu_iter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Opcode map and FSM state encoding for the iterative ALU, shared with the decoder.
// Optional feature macro: ALU_MULDIV_EN (adds the BUSY state for MUL/DIVU/REMU).
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_MUL  = 4'hA;
  localparam logic [3:0] ALU_DIVU = 4'hB;
  localparam logic [3:0] ALU_REMU = 4'hC;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} alu_state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} alu_state_t;
`endif

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Operand/result handshake bundle between issue logic (master) and the ALU (slave).
interface alu_iter_if #(parameter int N = 32);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] SrcA;
  logic [N-1:0] SrcB;
  logic [3:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] ALUResult;
  logic         Zero;
  logic         Carry;
  logic         Overflow;
  logic         Illegal;

  modport master (
    output in_valid, SrcA, SrcB, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Carry, Overflow, Illegal
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Carry, Overflow, Illegal
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider (MUL low half, DIVU, REMU).
// Instantiated by alu_iter only when ALU_MULDIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N) + 1;

  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [N-1:0]  x_q;    // multiplier (MUL) or dividend/quotient (DIV)
  logic [N-1:0]  y_q;    // multiplicand (MUL) or divisor (DIV)
  logic [N-1:0]  acc_q;  // product (MUL) or partial remainder (DIV)
  logic [N:0]    rem_sh;

  assign rem_sh = {acc_q, x_q[N-1]};

  // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(N);
      op_q  <= op;
      x_q   <= a;
      y_q   <= b;
      acc_q <= '0;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        if (op_q == ALU_MUL) begin
          if (x_q[0]) acc_q <= acc_q + y_q;
          x_q <= x_q >> 1;
          y_q <= y_q << 1;
        end else if (rem_sh >= {1'b0, y_q}) begin
          acc_q <= N'(rem_sh - {1'b0, y_q});
          x_q   <= {x_q[N-2:0], 1'b1};
        end else begin
          acc_q <= rem_sh[N-1:0];
          x_q   <= {x_q[N-2:0], 1'b0};
        end
      end
    end
  end

  assign done   = busy && (cnt == '0);
  assign result = (op_q == ALU_DIVU) ? x_q : acc_q;

endmodule

// File: rtl/alu_iter.sv
// Sequential N-bit RV32I ALU with valid/ready handshakes and registered result/flags.
// Optional feature macro: ALU_MULDIV_EN enables iterative MUL/DIVU/REMU; otherwise they are illegal.
module alu_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic    clk,
  input  logic    reset_n,
  alu_iter_if.slave bus
);

  localparam int SW = $clog2(N);

  alu_state_t    state;
  logic          accept;
  logic [N-1:0]  a, b, op_res;
  logic [SW-1:0] sh;
  logic [N:0]    add_w, sub_w;
  logic          op_carry, op_ovf, op_ill;

  assign a  = bus.SrcA;
  assign b  = bus.SrcB;
  assign sh = bus.SrcB[SW-1:0];

  assign bus.in_ready = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    add_w    = {1'b0, a} + {1'b0, b};
    sub_w    = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    op_ill   = 1'b0;
    case (bus.ALUControl)
      ALU_ADD: begin
        op_res   = add_w[N-1:0];
        op_carry = add_w[N];
        op_ovf   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        op_res   = sub_w[N-1:0];
        op_carry = sub_w[N];
        op_ovf   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
      end
      ALU_AND:  op_res = a & b;
      ALU_OR:   op_res = a | b;
      ALU_XOR:  op_res = a ^ b;
      ALU_SLT:  op_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: op_res = {{(N-1){1'b0}}, a < b};
      ALU_SLL:  op_res = a << sh;
      ALU_SRL:  op_res = a >> sh;
      ALU_SRA:  op_res = $signed(a) >>> sh;
      default:  op_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic         md_start, md_done;
  logic [N-1:0] md_res;

  assign md_start = accept & is_muldiv_op(bus.ALUControl);

  alu_muldiv_iter #(.N(N)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .op      (bus.ALUControl),
    .a       (a),
    .b       (b),
    .done    (md_done),
    .result  (md_res)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      bus.out_valid <= 1'b0;
      bus.ALUResult <= '0;
      bus.Zero      <= 1'b0;
      bus.Carry     <= 1'b0;
      bus.Overflow  <= 1'b0;
      bus.Illegal   <= 1'b0;
    end else
`ifdef ALU_MULDIV_EN
    if (state == S_BUSY) begin
      if (md_done) begin
        state         <= S_DONE;
        bus.out_valid <= 1'b1;
        bus.ALUResult <= md_res;
        bus.Zero      <= (md_res == '0);
        bus.Carry     <= 1'b0;
        bus.Overflow  <= 1'b0;
        bus.Illegal   <= 1'b0;
      end
    end else if (accept && is_muldiv_op(bus.ALUControl)) begin
      state         <= S_BUSY;
      bus.out_valid <= 1'b0;
    end else
`endif
    if (accept) begin
      state         <= S_DONE;
      bus.out_valid <= 1'b1;
      bus.ALUResult <= op_res;
      bus.Zero      <= (op_res == '0);
      bus.Carry     <= op_carry;
      bus.Overflow  <= op_ovf;
      bus.Illegal   <= op_ill;
    end else if (bus.out_ready) begin
      state         <= S_IDLE;
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at N=8; MUL/DIV tests follow ALU_MULDIV_EN.
module tb_alu_iter;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  alu_iter_if #(.N(8)) bus ();

  alu_iter #(.N(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.ALUResult !== 8'h00) begin n_fail++; $display("FAIL reset result: got %h want 00", bus.ALUResult); end
    n_chk++; if ({bus.Zero, bus.Carry, bus.Overflow, bus.Illegal} !== 4'b0000) begin n_fail++;
      $display("FAIL reset flags: got %b want 0000", {bus.Zero, bus.Carry, bus.Overflow, bus.Illegal}); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    bus.ALUControl = 4'h0; bus.SrcA = 8'h7F; bus.SrcB = 8'h01; bus.in_valid = 1'b1;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL add in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add out_valid: got %b want 1", bus.out_valid); end
    n_chk++; if (bus.ALUResult !== 8'h80) begin n_fail++; $display("FAIL add result: got %h want 80", bus.ALUResult); end
    n_chk++; if ({bus.Zero, bus.Carry, bus.Overflow, bus.Illegal} !== 4'b0010) begin n_fail++;
      $display("FAIL add flags: got %b want 0010", {bus.Zero, bus.Carry, bus.Overflow, bus.Illegal}); end
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add drain: got %b want 0", bus.out_valid); end
  endtask

  // Entries: {op, SrcA, SrcB, result, {Zero,Carry,Overflow,Illegal}}
  task automatic test_ops();
    logic [31:0] tab [16];
    tab = '{32'h1_05_05_00_C, 32'h5_FF_01_01_0, 32'h6_FF_01_00_8, 32'h9_80_03_F0_0,
            32'h9_80_0B_F0_0, 32'h8_80_03_10_0, 32'h7_81_03_08_0, 32'h2_F0_3C_30_0,
            32'h3_F0_0C_FC_0, 32'h4_FF_0F_F0_0, 32'h0_FF_01_00_C, 32'h1_03_05_FE_0,
            32'h1_80_01_7F_6, 32'h1_7F_FF_80_2, 32'hD_12_34_00_9, 32'hF_FF_FF_00_9};
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.ALUControl = tab[i][31:28]; bus.SrcA = tab[i][27:20]; bus.SrcB = tab[i][19:12];
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ops[%0d] out_valid: got %b want 1", i, bus.out_valid); end
      n_chk++; if (bus.ALUResult !== tab[i][11:4]) begin n_fail++;
        $display("FAIL ops[%0d] result: got %h want %h", i, bus.ALUResult, tab[i][11:4]); end
      n_chk++; if ({bus.Zero, bus.Carry, bus.Overflow, bus.Illegal} !== tab[i][3:0]) begin n_fail++;
        $display("FAIL ops[%0d] flags: got %b want %b", i, {bus.Zero, bus.Carry, bus.Overflow, bus.Illegal}, tab[i][3:0]); end
      tick();
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv();
    logic [31:0] tab [8];
    int lat;
    tab = '{32'hA_0D_0B_8F_0, 32'hA_FF_FF_01_0, 32'hB_C8_07_1C_0, 32'hC_C8_07_04_0,
            32'hB_55_00_FF_0, 32'hC_2A_00_2A_0, 32'hC_0E_07_00_8, 32'hB_07_C8_00_8};
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      bus.ALUControl = tab[i][31:28]; bus.SrcA = tab[i][27:20]; bus.SrcB = tab[i][19:12];
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
        n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL md[%0d] busy in_ready: got %b want 0", i, bus.in_ready); end
        tick();
        lat++;
      end
      n_chk++; if (lat != 9) begin n_fail++; $display("FAIL md[%0d] latency: got %0d want 9", i, lat); end
      n_chk++; if (bus.ALUResult !== tab[i][11:4]) begin n_fail++;
        $display("FAIL md[%0d] result: got %h want %h", i, bus.ALUResult, tab[i][11:4]); end
      n_chk++; if ({bus.Zero, bus.Carry, bus.Overflow, bus.Illegal} !== tab[i][3:0]) begin n_fail++;
        $display("FAIL md[%0d] flags: got %b want %b", i, {bus.Zero, bus.Carry, bus.Overflow, bus.Illegal}, tab[i][3:0]); end
      tick();
    end
  endtask
`else
  task automatic test_muldiv_illegal();
    logic [3:0] ops [3];
    ops = '{4'hA, 4'hB, 4'hC};
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      bus.ALUControl = ops[i]; bus.SrcA = 8'h0D; bus.SrcB = 8'h0B; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL md_ill[%0d] out_valid: got %b want 1", i, bus.out_valid); end
      n_chk++; if (bus.ALUResult !== 8'h00) begin n_fail++; $display("FAIL md_ill[%0d] result: got %h want 00", i, bus.ALUResult); end
      n_chk++; if ({bus.Zero, bus.Carry, bus.Overflow, bus.Illegal} !== 4'b1001) begin n_fail++;
        $display("FAIL md_ill[%0d] flags: got %b want 1001", i, {bus.Zero, bus.Carry, bus.Overflow, bus.Illegal}); end
      tick();
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] a_tab [4];
    logic [7:0] e_tab [4];
    a_tab = '{8'h01, 8'h11, 8'h21, 8'h31};
    e_tab = '{8'h02, 8'h12, 8'h22, 8'h32};
    bus.out_ready = 1'b0;
    bus.ALUControl = 4'h0; bus.SrcA = 8'h12; bus.SrcB = 8'h34; bus.in_valid = 1'b1;
    tick();
    bus.SrcA = 8'h55; bus.SrcB = 8'h11;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.ALUResult !== 8'h46) begin n_fail++;
        $display("FAIL hold[%0d]: got valid=%b result=%h want valid=1 result=46", i, bus.out_valid, bus.ALUResult); end
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] in_ready: got %b want 0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      bus.SrcA = a_tab[i]; bus.SrcB = 8'h01;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] in_ready: got %b want 1", i, bus.in_ready); end
      tick();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.ALUResult !== e_tab[i]) begin n_fail++;
        $display("FAIL b2b[%0d]: got valid=%b result=%h want valid=1 result=%h", i, bus.out_valid, bus.ALUResult, e_tab[i]); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_op();
    // Leave a nonzero result in place so the reset clear is observable.
    bus.out_ready = 1'b1;
    bus.ALUControl = 4'h0; bus.SrcA = 8'h12; bus.SrcB = 8'h34; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
`ifdef ALU_MULDIV_EN
    bus.ALUControl = 4'hA; bus.SrcA = 8'h0D; bus.SrcB = 8'h0B; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
`else
    bus.out_ready = 1'b0;
    bus.ALUControl = 4'h0; bus.SrcA = 8'h12; bus.SrcB = 8'h34; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
`endif
    reset_n = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.ALUResult !== 8'h00) begin n_fail++; $display("FAIL midrst result: got %h want 00", bus.ALUResult); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready: got %b want 1", bus.in_ready); end
    #2;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst stale valid: got %b want 0", bus.out_valid); end
`ifdef ALU_MULDIV_EN
    bus.ALUControl = 4'hA; bus.SrcA = 8'h0D; bus.SrcB = 8'h0B; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.ALUResult !== 8'h8F) begin n_fail++;
      $display("FAIL midrst next op: got valid=%b result=%h want valid=1 result=8f", bus.out_valid, bus.ALUResult); end
`else
    bus.ALUControl = 4'h0; bus.SrcA = 8'h7F; bus.SrcB = 8'h01; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.ALUResult !== 8'h80) begin n_fail++;
      $display("FAIL midrst next op: got valid=%b result=%h want valid=1 result=80", bus.out_valid, bus.ALUResult); end
`endif
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.SrcA = '0;
    bus.SrcB = '0;
    bus.ALUControl = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_ops();
`ifdef ALU_MULDIV_EN
    test_muldiv();
`else
    test_muldiv_illegal();
`endif
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
